// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 frame-capture path.
//   cam_state_e  : capture sequencer state encoding
//   PIXEL_W      : RGB565 pixel width
//   CNT_W        : width of the per-frame x/y pixel and line counters
//   VGA_H_ACTIVE / VGA_V_ACTIVE : default active raster, shared with HDMI_VPG
//   sat_inc()    : saturating counter increment
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StSync,
        StCapture,
        StDone
    } cam_state_e;

    localparam int unsigned PIXEL_W      = 16;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_V_ACTIVE = 480;

    // Counters stick at all-ones so an over-long line or frame can never wrap
    // back into the kept window.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Assembles RGB565 pixels from the camera byte stream.
// Ports:
//   clk, reset : camera PCLK, synchronous active-high reset
//   enable     : sample bytes (sequencer is in CAPTURE)
//   clear      : restart at byte phase 0 (entering CAPTURE)
//   href, data : camera byte qualifier and byte bus
//   pix_valid  : completion strobe, same cycle as the second byte is sampled
//   pix_data   : completed pixel, first byte in [15:8]; valid with pix_valid
//   line_end   : href falling edge while enabled
module cam_byte_packer
    import cam_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               href,
    input  logic [7:0]         data,
    output logic               pix_valid,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               line_end
);

    logic       href_q;
    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
        end else begin
            href_q  <= href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        hi_d      = hi_q;
        pix_valid = 1'b0;
        pix_data  = {hi_q, data};
        line_end  = enable && href_q && !href;
        if (clear) begin
            phase_d = 1'b0;
        end else if (enable) begin
            if (href) begin
                if (!phase_q) begin
                    hi_d    = data;
                    phase_d = 1'b1;
                end else begin
                    pix_valid = 1'b1;
                    phase_d   = 1'b0;
                end
            end else if (href_q) begin
                // An odd trailing byte is abandoned at end of line.
                phase_d = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670 frame-capture sequencer: arms on start, aligns to VSYNC, packs byte
// pairs into RGB565 pixels and writes them with linear addresses to a frame
// buffer over a valid/ready handshake.
// Optional build macro: CAM_DECIMATE_EN (2:1 decimation in both axes).
// Ports:
//   clk, reset          : camera PCLK, synchronous active-high reset
//   start               : capture request, honoured only in IDLE
//   continuous          : re-arm after each frame (sampled in DONE)
//   cam_vsync, cam_href : camera sync (pre-synchronised) and byte qualifier
//   cam_data            : camera byte bus
//   wr_valid, wr_ready  : frame-buffer write handshake
//   wr_addr, wr_data    : linear pixel address and RGB565 pixel
//   busy                : sequencer not IDLE
//   frame_done          : one-cycle pulse in DONE
//   frame_err           : sticky, last frame's line count != V_ACTIVE
//   overflow            : sticky, a pixel was dropped under backpressure
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned ADDR_W      = 19,
    parameter bit          VS_ACT_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIXEL_W-1:0] wr_data,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACTIVE);

    cam_state_e state_q, state_d;

    logic               vs_act;
    logic               enter_cap;
    logic               capturing;
    logic               pix_valid;
    logic [PIXEL_W-1:0] pix_data;
    logic               line_end;
    logic               keep;
    logic [CNT_W-1:0]   lines_kept;

    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic               line_pix_q, line_pix_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_W-1:0] wr_data_q, wr_data_d;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q, overflow_d;

    assign vs_act    = VS_ACT_HIGH ? cam_vsync : !cam_vsync;
    assign capturing = (state_q == StCapture);
    assign enter_cap = (state_q == StSync) && !vs_act;

    cam_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .enable    (capturing),
        .clear     (enter_cap),
        .href      (cam_href),
        .data      (cam_data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .line_end  (line_end)
    );

    // x/y count source pixels and source lines; keep selects what is written.
`ifdef CAM_DECIMATE_EN
    assign keep = !x_q[0] && !y_q[0] && ((x_q >> 1) < H_LIM) && ((y_q >> 1) < V_LIM);
    assign lines_kept = (y_q + 1'b1) >> 1;
`else
    assign keep = (x_q < H_LIM) && (y_q < V_LIM);
    assign lines_kept = y_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start)      state_d = StArm;
            StArm:     if (vs_act)     state_d = StSync;
            StSync:    if (!vs_act)    state_d = StCapture;
            StCapture: if (vs_act)     state_d = StDone;
            StDone:    state_d = continuous ? StArm : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        line_pix_d  = line_pix_q;
        addr_d      = addr_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;

        // Acceptance first so a same-cycle completion can reload the register.
        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        if (enter_cap) begin
            x_d         = '0;
            y_d         = '0;
            line_pix_d  = 1'b0;
            addr_d      = '0;
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end

        if (capturing) begin
            if (line_end) begin
                if (line_pix_q) begin
                    y_d = sat_inc(y_q);
                end
                x_d        = '0;
                line_pix_d = 1'b0;
            end
            if (pix_valid) begin
                x_d        = sat_inc(x_q);
                line_pix_d = 1'b1;
                if (keep) begin
                    addr_d = addr_q + 1'b1;
                    if (!wr_valid_q || wr_ready) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = pix_data;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end

        if (state_q == StDone) begin
            frame_err_d = (lines_kept != V_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            line_pix_q  <= 1'b0;
            addr_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            line_pix_q  <= line_pix_d;
            addr_q      <= addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
